johnson_seq_ctrl: RTL

- Sequencing controller wrapped around a WIDTH-bit Johnson (twisted-ring) counter.
- Runs the ring for a programmed number of steps, or continuously, in either direction.
- Supports hold, stop and preload, and reports busy, done, wrap and illegal-code status.
- Used wherever the Johnson phase generator must be started and stopped under control of higher-level logic.

---
 rtl/johnson_seq_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/johnson_seq_ctrl.sv
// Sequencing controller around a WIDTH-bit Johnson (twisted-ring) counter.
// Runs the ring for a programmed number of steps or continuously, forward or
// reverse, with hold, stop and an IDLE-only preload. Every output is registered.
//
// Ports:
//   clk       in   clock, rising edge active
//   res       in   asynchronous active-low reset
//   start     in   begin a run (IDLE only)
//   stop      in   abort a run (RUN only, beats hold)
//   hold      in   freeze ring and step count while in RUN
//   dir       in   0 = forward, 1 = reverse, sampled every step
//   cont      in   continuous mode, sampled when start is accepted
//   n_steps   in   step count for a counted run, sampled when start is accepted
//   load      in   preload the ring (IDLE only, start takes precedence)
//   load_val  in   preload value
//   q         out  ring state
//   phase     out  decoded phase index of q
//   busy      out  high while in RUN
//   done      out  one-cycle pulse when a counted run completes
//   wrap      out  one-cycle pulse after a step lands on all-zeros
//   err       out  sticky illegal-preload flag, cleared by an accepted start
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int PH_W  = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             dir,
  input  logic             cont,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PH_W-1:0]  phase,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Code with the low k bits set (phases 0..WIDTH).
  function automatic logic [WIDTH-1:0] lo_code(input int k);
    logic [WIDTH-1:0] c;
    for (int b = 0; b < WIDTH; b++) c[b] = (b < k);
    return c;
  endfunction

  // All ones except the low j bits cleared (phases WIDTH+1..2*WIDTH-1).
  function automatic logic [WIDTH-1:0] hi_code(input int j);
    logic [WIDTH-1:0] c;
    for (int b = 0; b < WIDTH; b++) c[b] = (b >= j);
    return c;
  endfunction

  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    logic legal;
    legal = 1'b0;
    for (int k = 0; k <= WIDTH; k++) if (v == lo_code(k)) legal = 1'b1;
    for (int j = 1; j < WIDTH; j++) if (v == hi_code(j)) legal = 1'b1;
    return legal;
  endfunction

  function automatic logic [PH_W-1:0] phase_of(input logic [WIDTH-1:0] v);
    logic [PH_W-1:0] p;
    p = '0;
    for (int k = 0; k <= WIDTH; k++) if (v == lo_code(k)) p = PH_W'(k);
    for (int j = 1; j < WIDTH; j++) if (v == hi_code(j)) p = PH_W'(WIDTH + j);
    return p;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             cont_q, cont_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             step_en;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    cont_d  = cont_q;
    err_d   = err_q;
    step_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d  = n_steps;
          cont_d = cont;
          err_d  = 1'b0;
          // A zero-length counted run completes without touching the ring.
          state_d = (!cont && n_steps == '0) ? StDone : StRun;
        end else if (load) begin
          if (is_legal(load_val)) begin
            q_d = load_val;
          end else begin
            q_d   = '0;
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          rem_d   = '0;
        end else if (!hold) begin
          step_en = 1'b1;
          q_d = dir ? {~q_q[0], q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
          if (!cont_q) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from next-state so they line up with q_q.
    phase_d = phase_of(q_d);
    busy_d  = (state_d == StRun);
    done_d  = (state_d == StDone);
    wrap_d  = step_en && (q_d == '0);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= StIdle;
      q_q     <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      cont_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign q     = q_q;
  assign phase = phase_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule
